multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the lab CPU datapath. It fetches each instruction over a ready/request handshake with instruction memory, decodes the 6-bit opcode, and steps the datapath through EXEC and WB phases. It drives the per-phase register-write, ALU and PC enables and counts retired instructions. It sits between the PC/IR registers, the register file/ALU datapath and the instruction memory port.

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/multicycle_op_decode.sv | 54 +++++
 rtl/multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTIU = 6'b001011;

    localparam logic [2:0] ALU_OP_FUNCT = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_ADD   = 3'b010;
    localparam logic [2:0] ALU_OP_LUI   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;
    localparam logic [2:0] ALU_OP_SLTU  = 3'b101;

endpackage

// File: rtl/multicycle_op_decode.sv
// Combinational opcode decoder: opcode -> legality and datapath control fields.
module multicycle_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       legal,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       se,
    output logic       reg_dst,
    output logic       is_branch
);

    always_comb begin
        legal     = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        alu_src   = 1'b0;
        se        = 1'b0;
        reg_dst   = 1'b0;
        is_branch = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_dst = 1'b1;
            end
            OP_BEQ: begin
                alu_op    = ALU_OP_SUB;
                se        = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI: begin
                alu_op  = ALU_OP_ADD;
                alu_src = 1'b1;
                se      = 1'b1;
            end
            OP_LUI: begin
                alu_op  = ALU_OP_LUI;
                alu_src = 1'b1;
            end
            OP_ORI: begin
                alu_op  = ALU_OP_OR;
                alu_src = 1'b1;
            end
            OP_SLTIU: begin
                alu_op  = ALU_OP_SLTU;
                alu_src = 1'b1;
                se      = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetch handshake, decode, EXEC/WB phase enables
// and retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [5:0]       instr_op_i,
    input  logic             imem_ready_i,
    input  logic             zero_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic [2:0]       alu_op_o,
    output logic             se_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic [5:0] dec_op;
    logic       dec_legal;
    logic [2:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_se;
    logic       dec_reg_dst;
    logic       dec_branch;

    // One decoder serves both the DECODE legality check (op_q not loaded yet)
    // and the EXEC/WB field drive from op_q.
    assign dec_op = (state_q == S_DECODE) ? instr_op_i : op_q;

    multicycle_op_decode u_dec (
        .op        (dec_op),
        .legal     (dec_legal),
        .alu_op    (dec_alu_op),
        .alu_src   (dec_alu_src),
        .se        (dec_se),
        .reg_dst   (dec_reg_dst),
        .is_branch (dec_branch)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= instr_op_i;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        imem_req_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        reg_write_o = 1'b0;
        reg_dst_o   = 1'b0;
        alu_src_o   = 1'b0;
        alu_op_o    = '0;
        se_o        = 1'b0;
        illegal_o   = 1'b0;
        busy_o      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
                if (imem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_op_o  = dec_alu_op;
                alu_src_o = dec_alu_src;
                se_o      = dec_se;
                if (dec_branch) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = zero_i;
                    retire     = 1'b1;
                    state_d    = stop_i ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                alu_op_o    = dec_alu_op;
                alu_src_o   = dec_alu_src;
                se_o        = dec_se;
                reg_write_o = 1'b1;
                reg_dst_o   = dec_reg_dst;
                pc_write_o  = 1'b1;
                retire      = 1'b1;
                state_d     = stop_i ? S_IDLE : S_FETCH;
            end
            S_TRAP: begin
                illegal_o = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction cycle plans produce the
// expected output vector for every cycle, checked at the falling edge.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic [5:0]       instr_op_i = '0;
    logic             imem_ready_i = 1'b0;
    logic             zero_i = 1'b0;
    logic             imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o;
    logic             reg_dst_o, alu_src_o, se_o, busy_o, illegal_o;
    logic [2:0]       alu_op_o;
    logic [CNT_W-1:0] retired_o;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .instr_op_i   (instr_op_i),
        .imem_ready_i (imem_ready_i),
        .zero_i       (zero_i),
        .imem_req_o   (imem_req_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .alu_src_o    (alu_src_o),
        .alu_op_o     (alu_op_o),
        .se_o         (se_o),
        .busy_o       (busy_o),
        .illegal_o    (illegal_o),
        .retired_o    (retired_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, irw, pcw, pcs, rw, rd, as;
        logic [2:0] aop;
        logic       se, busy, ill;
    } outs_t;

    outs_t            got, exp_o;
    logic [CNT_W-1:0] exp_ret = '0;
    logic             chk_en = 1'b0;
    logic             pend_ret = 1'b0;
    int               n_cmp = 0, n_bad = 0;
    int               cnt_req = 0, cnt_irw = 0, cnt_pcw = 0, cnt_rw = 0;

    assign got = {imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
                  alu_src_o, alu_op_o, se_o, busy_o, illegal_o};

    always @(negedge clk) begin
        if (chk_en) begin
            cnt_req += int'(got.req);
            cnt_irw += int'(got.irw);
            cnt_pcw += int'(got.pcw);
            cnt_rw  += int'(got.rw);
            n_cmp++;
            if ({got, retired_o} !== {exp_o, exp_ret}) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t got=%h ret=%0d required=%h ret=%0d",
                         $time, got, retired_o, exp_o, exp_ret);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", nm, g, e);
        end
    endtask

    // {legal, branch, alu_op[2:0], alu_src, se, reg_dst}
    function automatic logic [7:0] model_info(input logic [5:0] op);
        case (op)
            6'b000000: return 8'b1_0_000_0_0_1;
            6'b000100: return 8'b1_1_001_0_1_0;
            6'b001000: return 8'b1_0_010_1_1_0;
            6'b001111: return 8'b1_0_011_1_0_0;
            6'b001101: return 8'b1_0_100_1_0_0;
            6'b001011: return 8'b1_0_101_1_1_0;
            default:   return 8'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_ret) begin
            exp_ret  = exp_ret + 1'b1;
            pend_ret = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; chk_en = 1'b0; pend_ret = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; imem_ready_i = 1'b0; zero_i = 1'b0; instr_op_i = '0;
        step();
        step();
        rst_i = 1'b0; exp_ret = '0; exp_o = '0; chk_en = 1'b1;
    endtask

    // Entered positioned in a FETCH cycle; leaves in the next FETCH cycle, or in
    // IDLE when stopping without restart, or with reset held when rst_wb is set.
    task automatic run_instr(input logic [5:0] op, input int stalls, input logic zero,
                             input logic stop, input logic restart, input logic rst_wb);
        logic [7:0] inf;
        int         n_idle;
        inf = model_info(op);
        for (int k = 0; k <= stalls; k++) begin
            if (k > 0) step();
            imem_ready_i = (k == stalls);
            instr_op_i = 6'($urandom); start_i = 1'($urandom);
            stop_i = 1'($urandom); zero_i = 1'($urandom);
            exp_o = '0; exp_o.req = 1'b1; exp_o.irw = imem_ready_i; exp_o.busy = 1'b1;
        end
        step();
        instr_op_i = op; imem_ready_i = 1'($urandom); start_i = 1'($urandom);
        exp_o = '0; exp_o.busy = 1'b1;
        if (!inf[7]) begin
            for (int k = 0; k < 20; k++) begin
                step();
                start_i = 1'($urandom); stop_i = 1'($urandom);
                imem_ready_i = 1'($urandom); instr_op_i = 6'($urandom);
                exp_o = '0; exp_o.busy = 1'b1; exp_o.ill = 1'b1;
            end
            return;
        end
        step();
        instr_op_i = 6'($urandom); zero_i = zero; start_i = 1'($urandom);
        exp_o = '0; exp_o.busy = 1'b1;
        exp_o.aop = inf[5:3]; exp_o.as = inf[2]; exp_o.se = inf[1];
        if (inf[6]) begin
            exp_o.pcw = 1'b1; exp_o.pcs = zero;
            stop_i = stop; pend_ret = 1'b1;
        end else begin
            stop_i = 1'($urandom);
            step();
            instr_op_i = 6'($urandom); zero_i = 1'($urandom); start_i = 1'($urandom);
            exp_o.rw = 1'b1; exp_o.rd = inf[0]; exp_o.pcw = 1'b1;
            stop_i = stop; pend_ret = 1'b1;
            if (rst_wb) begin
                #1;
                rst_i = 1'b1; chk_en = 1'b0; pend_ret = 1'b0;
                #1;
                check("reset_outputs", 32'(got), 32'h0);
                check("reset_retired", 32'(retired_o), 32'h0);
                return;
            end
        end
        step();
        start_i = 1'b0;
        if (stop) begin
            exp_o = '0; stop_i = 1'($urandom);
            if (restart) begin
                n_idle = $urandom_range(0, 2);
                for (int k = 0; k < n_idle; k++) begin
                    start_i = 1'b0; stop_i = 1'($urandom); exp_o = '0;
                    step();
                end
                start_i = 1'b1; exp_o = '0;
                step();
                start_i = 1'b0;
            end
        end
    endtask

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b000100, 6'b001000, 6'b001111, 6'b001101, 6'b001011};
    int s_req, s_irw, s_pcw, s_rw;

    initial begin
        do_reset();
        check("reset_retired_init", 32'(retired_o), 32'h0);
        check("reset_busy_init", 32'(busy_o), 32'h0);
        for (int k = 0; k < 3; k++) begin
            stop_i = 1'($urandom); start_i = 1'b0; exp_o = '0;
            step();
        end
        start_i = 1'b1; exp_o = '0;
        step();
        start_i = 1'b0;

        run_instr(6'b001000, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("addi_retired", 32'(retired_o), 32'd1);

        s_rw = cnt_rw; s_pcw = cnt_pcw;
        run_instr(6'b000100, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(6'b000100, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("beq_reg_write_cycles", 32'(cnt_rw - s_rw), 32'd0);
        check("beq_pc_write_cycles", 32'(cnt_pcw - s_pcw), 32'd2);
        check("beq_retired", 32'(retired_o), 32'd3);

        s_req = cnt_req; s_irw = cnt_irw; s_pcw = cnt_pcw;
        run_instr(6'b001101, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stall_req_cycles", 32'(cnt_req - s_req), 32'd4);
        check("stall_irw_cycles", 32'(cnt_irw - s_irw), 32'd1);
        check("stall_pcw_cycles", 32'(cnt_pcw - s_pcw), 32'd1);
        check("stall_retired", 32'(retired_o), 32'd4);

        for (int i = 0; i < 60; i++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3), 1'($urandom),
                      1'($urandom_range(0, 4) == 0), 1'b1, 1'b0);
        end

        run_instr(6'b001000, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        rst_i = 1'b0; exp_ret = '0; chk_en = 1'b1; exp_o = '0;
        for (int k = 0; k < 3; k++) begin
            start_i = 1'b0; stop_i = 1'($urandom); exp_o = '0;
            step();
        end
        start_i = 1'b1; exp_o = '0;
        step();
        start_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_instr(6'b000000, $urandom_range(0, 2), 1'($urandom), 1'(i == 15), 1'b0, 1'b0);
        end
        check("wrap_retired", 32'(retired_o), 32'd0);
        check("stop_busy", 32'(busy_o), 32'd0);

        start_i = 1'b1; exp_o = '0;
        step();
        start_i = 1'b0;
        s_pcw = cnt_pcw; s_rw = cnt_rw;
        run_instr(6'b100011, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, 1'b0);
        check("trap_illegal", 32'(illegal_o), 32'd1);
        check("trap_busy", 32'(busy_o), 32'd1);
        check("trap_pc_write_cycles", 32'(cnt_pcw - s_pcw), 32'd0);
        check("trap_reg_write_cycles", 32'(cnt_rw - s_rw), 32'd0);

        do_reset();
        check("post_trap_illegal", 32'(illegal_o), 32'd0);
        check("post_trap_busy", 32'(busy_o), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
